// File: rtl/ram_port_arbiter_if.sv
// Request/response bundle for the two RAM requesters plus the RAM-facing bus.
// Latency: none (wires only).
// Backpressure: requesters hold their request until the matching gnt is seen.
interface ram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  // port 0 (BIST side)
  logic          req0;
  logic          we0;
  logic          lock0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;
  // port 1 (functional side)
  logic          req1;
  logic          we1;
  logic          lock1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;
  // single-port RAM
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  // arbiter side
  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    input  req1, we1, lock1, addr1, wdata1,
    input  ram_q,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_addr, ram_wdata, ram_wren
  );

  // requester / RAM side
  modport master (
    output req0, we0, lock0, addr0, wdata0,
    output req1, we1, lock1, addr1, wdata1,
    output ram_q,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_addr, ram_wdata, ram_wren
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port sync RAM between BIST (port 0) and user (port 1), with ownership lock.
// Latency: grant is combinational; read data returns exactly 1 cycle after the accepted read.
// Backpressure: a losing requester sees gnt=0 and must hold its request stable; read returns cannot be stalled.
module ram_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input logic                 clk,
  input logic                 reset,
  ram_port_arbiter_if.slave   io_bus
);

  logic          r_last;     // last granted port, loser of the next tie
  logic          r_locked;
  logic          r_owner;
  logic          r_rd_pend;
  logic          r_rd_port;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_acc;
  logic          w_we;
  logic          w_lock;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // Grant selection: lock owner only, else single requester, else alternate on tie.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      if (r_locked) begin
        if (r_owner) w_gnt1 = io_bus.req1;
        else         w_gnt0 = io_bus.req0;
      end else if (io_bus.req0 && io_bus.req1) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = io_bus.req0;
        w_gnt1 = io_bus.req1;
      end
    end
  end

  // Mux the granted port onto the RAM; port 0 fields pass through when idle (wren is 0 then).
  always_comb begin
    w_acc   = w_gnt0 | w_gnt1;
    w_addr  = w_gnt1 ? io_bus.addr1  : io_bus.addr0;
    w_wdata = w_gnt1 ? io_bus.wdata1 : io_bus.wdata0;
    w_we    = w_gnt1 ? io_bus.we1    : (w_gnt0 & io_bus.we0);
    w_lock  = w_gnt1 ? io_bus.lock1  : (w_gnt0 & io_bus.lock0);
  end

  assign io_bus.gnt0      = w_gnt0;
  assign io_bus.gnt1      = w_gnt1;
  assign io_bus.ram_addr  = w_addr;
  assign io_bus.ram_wdata = w_wdata;
  assign io_bus.ram_wren  = w_we;

  // Read return: RAM output goes to both ports, the valid steers it to the issuer.
  assign io_bus.rvalid0 = reset & r_rd_pend & !r_rd_port;
  assign io_bus.rvalid1 = reset & r_rd_pend &  r_rd_port;
  assign io_bus.rdata0  = io_bus.ram_q;
  assign io_bus.rdata1  = io_bus.ram_q;

  // Arbitration history, lock ownership and the one-deep read tracker.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last    <= 1'b1;
      r_locked  <= 1'b0;
      r_owner   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_port <= 1'b0;
    end else if (w_acc) begin
      r_last    <= w_gnt1;
      r_rd_pend <= !w_we;
      r_rd_port <= w_gnt1;
      if (w_lock) begin
        r_locked <= 1'b1;
        r_owner  <= w_gnt1;
      end else if (r_locked && (r_owner == w_gnt1)) begin
        r_locked <= 1'b0;
      end
    end else begin
      r_rd_pend <= 1'b0;
      // No grant while locked means the owner stopped requesting: release.
      if (r_locked) r_locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [7:0] ram    [256];
  logic [7:0] shadow [256];

  ram_port_arbiter_if #(.AW(8), .DW(8)) bus ();

  ram_port_arbiter #(.AW(8), .DW(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // behavioural single-port RAM, registered read
  always @(posedge clk) begin
    if (bus.ram_wren) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_q <= ram[bus.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0 = 0; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    bus.req0 = 1; bus.we0 = 1; bus.req1 = 1; bus.we1 = 1;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      tests_failed++; $display("FAIL reset_gnt got=%b%b exp=00", bus.gnt0, bus.gnt1);
    end
    tests_run++;
    if (bus.ram_wren !== 1'b0) begin
      tests_failed++; $display("FAIL reset_wren got=%b exp=0", bus.ram_wren);
    end
    tests_run++;
    if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
      tests_failed++; $display("FAIL reset_rvalid got=%b%b exp=00", bus.rvalid0, bus.rvalid1);
    end
    tick();
    idle();
    reset = 1;
    tick();
  endtask

  task automatic test_fill();
    int writes = 0;
    do_reset();
    for (int a = 0; a < 256; a++) begin
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'(a); bus.wdata0 = 8'h55;
      @(negedge clk);
      tests_run++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
        tests_failed++; $display("FAIL fill_gnt a=%0d got=%b%b exp=10", a, bus.gnt0, bus.gnt1);
      end
      tests_run++;
      if (bus.ram_wren !== 1'b1 || bus.ram_addr !== 8'(a) || bus.ram_wdata !== 8'h55) begin
        tests_failed++;
        $display("FAIL fill_ram a=%0d got wren=%b addr=%h data=%h exp 1/%h/55",
                 a, bus.ram_wren, bus.ram_addr, bus.ram_wdata, 8'(a));
      end
      if (bus.gnt0 === 1'b1 && bus.ram_wren === 1'b1) writes++;
      shadow[a] = 8'h55;
      tick();
    end
    idle();
    tests_run++;
    if (writes != 256) begin
      tests_failed++; $display("FAIL fill_count got=%0d exp=256", writes);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp_d;
    do_reset();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA1;
    tick();
    bus.addr0 = 8'h20; bus.wdata0 = 8'hB2;
    tick();
    shadow[8'h10] = 8'hA1; shadow[8'h20] = 8'hB2;
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h20;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) idle();
      @(negedge clk);
      if (i < 6) begin
        tests_run++;
        if (bus.gnt0 !== ((i % 2) == 0) || bus.gnt1 !== ((i % 2) == 1)) begin
          tests_failed++; $display("FAIL alt_gnt i=%0d got=%b%b", i, bus.gnt0, bus.gnt1);
        end
      end
      if (i > 0) begin
        exp_d = ((i - 1) % 2 == 0) ? 8'hA1 : 8'hB2;
        tests_run++;
        if (bus.rvalid0 !== ((i - 1) % 2 == 0) || bus.rvalid1 !== ((i - 1) % 2 == 1)) begin
          tests_failed++; $display("FAIL alt_rvalid i=%0d got=%b%b", i, bus.rvalid0, bus.rvalid1);
        end
        tests_run++;
        if (((i - 1) % 2 == 0 ? bus.rdata0 : bus.rdata1) !== exp_d) begin
          tests_failed++;
          $display("FAIL alt_rdata i=%0d got=%h/%h exp=%h", i, bus.rdata0, bus.rdata1, exp_d);
        end
      end
      tick();
    end
  endtask

  task automatic test_lock0();
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.lock0 = 1; bus.addr0 = 8'h05;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h30;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      tests_failed++; $display("FAIL lock0_c1 got=%b%b exp=10", bus.gnt0, bus.gnt1);
    end
    tick();
    bus.we0 = 1; bus.lock0 = 0; bus.wdata0 = 8'hAA;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.ram_wren !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock0_c2 got gnt=%b%b wren=%b exp 10/1", bus.gnt0, bus.gnt1, bus.ram_wren);
    end
    tests_run++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== shadow[8'h05]) begin
      tests_failed++;
      $display("FAIL lock0_rd got v=%b d=%h exp 1/%h", bus.rvalid0, bus.rdata0, shadow[8'h05]);
    end
    tick();
    shadow[8'h05] = 8'hAA;
    bus.req0 = 0; bus.we0 = 0;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b1) begin
      tests_failed++; $display("FAIL lock0_c3 got=%b%b exp=01", bus.gnt0, bus.gnt1);
    end
    tick();
    bus.addr1 = 8'h05;
    @(negedge clk);
    tests_run++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== shadow[8'h30]) begin
      tests_failed++;
      $display("FAIL lock0_rd1 got v=%b d=%h exp 1/%h", bus.rvalid1, bus.rdata1, shadow[8'h30]);
    end
    tick();
    idle();
    @(negedge clk);
    tests_run++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 8'hAA) begin
      tests_failed++; $display("FAIL lock0_wr got v=%b d=%h exp 1/aa", bus.rvalid1, bus.rdata1);
    end
    tick();
  endtask

  task automatic test_lock1_drop();
    do_reset();
    bus.req1 = 1; bus.we1 = 0; bus.lock1 = 1; bus.addr1 = 8'h40;
    @(negedge clk);
    tests_run++;
    if (bus.gnt1 !== 1'b1) begin
      tests_failed++; $display("FAIL drop_lock got=%b exp=1", bus.gnt1);
    end
    tick();
    bus.req1 = 0; bus.lock1 = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h41;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      tests_failed++; $display("FAIL drop_locked got=%b%b exp=00", bus.gnt0, bus.gnt1);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b1) begin
      tests_failed++; $display("FAIL drop_after got=%b exp=1", bus.gnt0);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_write_read();
    do_reset();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h7F; bus.wdata1 = 8'h3C;
    @(negedge clk);
    tests_run++;
    if (bus.gnt1 !== 1'b1 || bus.ram_wren !== 1'b1) begin
      tests_failed++; $display("FAIL wr_gnt got gnt=%b wren=%b exp 1/1", bus.gnt1, bus.ram_wren);
    end
    tick();
    shadow[8'h7F] = 8'h3C;
    bus.we1 = 0;
    @(negedge clk);
    tests_run++;
    if (bus.gnt1 !== 1'b1 || bus.ram_wren !== 1'b0 || bus.rvalid1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_gnt got gnt=%b wren=%b rv=%b exp 1/0/0", bus.gnt1, bus.ram_wren, bus.rvalid1);
    end
    tick();
    idle();
    @(negedge clk);
    tests_run++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 8'h3C || bus.rvalid0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_data got v1=%b d=%h v0=%b exp 1/3c/0", bus.rvalid1, bus.rdata1, bus.rvalid0);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h7F;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b1) begin
      tests_failed++; $display("FAIL rstrd_gnt got=%b exp=1", bus.gnt0);
    end
    tick();
    reset = 0;
    bus.we0 = 1; bus.req1 = 1; bus.we1 = 1;
    @(negedge clk);
    tests_run++;
    if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
      tests_failed++; $display("FAIL rstrd_rvalid got=%b%b exp=00", bus.rvalid0, bus.rvalid1);
    end
    tests_run++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.ram_wren !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstrd_gnt0 got gnt=%b%b wren=%b exp 00/0", bus.gnt0, bus.gnt1, bus.ram_wren);
    end
    tick();
    reset = 1;
    bus.we0 = 0; bus.we1 = 0;
    @(negedge clk);
    tests_run++;
    if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
      tests_failed++; $display("FAIL rstrd_stale got=%b%b exp=00", bus.rvalid0, bus.rvalid1);
    end
    tests_run++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      tests_failed++; $display("FAIL rstrd_tie got=%b%b exp=10", bus.gnt0, bus.gnt1);
    end
    tick();
    idle();
    tick();
  endtask

  // Transaction-level reference: who may own the RAM, who wins a tie, what a read returns.
  bit         m_last, m_locked, m_owner;
  bit         e_rv;
  int         e_rp;
  logic [7:0] e_rd;

  function automatic int model_winner(bit r0, bit r1);
    if (m_locked) begin
      if (m_owner) return r1 ? 1 : -1;
      return r0 ? 0 : -1;
    end
    if (r0 && r1) return m_last ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic test_random();
    bit         req [2];
    bit         we  [2];
    bit         lk  [2];
    logic [7:0] ad  [2];
    logic [7:0] wd  [2];
    bit         hold [2];
    int         win;
    do_reset();
    m_last = 1; m_locked = 0; m_owner = 0; e_rv = 0; e_rp = 0; e_rd = '0;
    hold[0] = 0; hold[1] = 0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; lk[p] = 0; ad[p] = 0; wd[p] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          req[p] = ($urandom_range(0, 3) != 0);
          we[p]  = $urandom_range(0, 1) == 1;
          lk[p]  = ($urandom_range(0, 3) == 0);
          ad[p]  = 8'($urandom_range(0, 15));
          wd[p]  = 8'($urandom);
        end
      end
      bus.req0 = req[0]; bus.we0 = we[0]; bus.lock0 = lk[0]; bus.addr0 = ad[0]; bus.wdata0 = wd[0];
      bus.req1 = req[1]; bus.we1 = we[1]; bus.lock1 = lk[1]; bus.addr1 = ad[1]; bus.wdata1 = wd[1];
      win = model_winner(req[0], req[1]);
      @(negedge clk);
      tests_run++;
      if (bus.gnt0 !== (win == 0) || bus.gnt1 !== (win == 1)) begin
        tests_failed++; $display("FAIL rnd_gnt c=%0d got=%b%b exp_win=%0d", c, bus.gnt0, bus.gnt1, win);
      end
      tests_run++;
      if (bus.ram_wren !== ((win >= 0) && we[win == 1])) begin
        tests_failed++; $display("FAIL rnd_wren c=%0d got=%b", c, bus.ram_wren);
      end
      if (win >= 0) begin
        tests_run++;
        if (bus.ram_addr !== ad[win] || (we[win] && bus.ram_wdata !== wd[win])) begin
          tests_failed++;
          $display("FAIL rnd_ram c=%0d got %h/%h exp %h/%h", c, bus.ram_addr, bus.ram_wdata, ad[win], wd[win]);
        end
      end
      tests_run++;
      if (bus.rvalid0 !== (e_rv && e_rp == 0) || bus.rvalid1 !== (e_rv && e_rp == 1)) begin
        tests_failed++; $display("FAIL rnd_rvalid c=%0d got=%b%b exp_rv=%b port=%0d", c,
                                 bus.rvalid0, bus.rvalid1, e_rv, e_rp);
      end
      if (e_rv) begin
        tests_run++;
        if ((e_rp == 1 ? bus.rdata1 : bus.rdata0) !== e_rd) begin
          tests_failed++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h", c, bus.rdata0, bus.rdata1, e_rd);
        end
      end
      @(posedge clk);
      if (win >= 0) begin
        m_last = (win == 1);
        if (we[win]) begin
          shadow[ad[win]] = wd[win];
          e_rv = 0;
        end else begin
          e_rv = 1; e_rp = win; e_rd = shadow[ad[win]];
        end
        if (lk[win]) begin
          m_locked = 1; m_owner = (win == 1);
        end else if (m_locked) begin
          m_locked = 0;
        end
      end else begin
        e_rv = 0;
        m_locked = 0;
      end
      for (int p = 0; p < 2; p++) hold[p] = req[p] && (win != p);
      #1;
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_alternate();
    test_lock0();
    test_lock1_drop();
    test_write_read();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (ram_1port style: addr, data, wren, q) between two requesters.
- Port 0 is the memory-test/BIST side. Port 1 is the functional user side.
- Arbitration is round-robin per transaction, with an optional lock so one port can own the RAM for a multi-cycle sequence (e.g. a march-element read/write pair).
- Routes read data back to the requester that issued the read.

Parameters:
- AW, 8, address width (RAM depth 2^AW)
- DW, 8, data width

Ports:
- clk  input  1  rising-edge clock; the RAM uses the same clock
- reset  input  1  reset, synchronous, active-low
- req0  input  1  port 0 requests a transaction this cycle
- we0  input  1  port 0: 1 = write, 0 = read
- lock0  input  1  port 0 requests ownership beyond this transaction
- addr0  input  AW  port 0 address
- wdata0  input  DW  port 0 write data
- gnt0  output  1  port 0 transaction accepted at the next rising edge
- rvalid0  output  1  port 0 read data valid
- rdata0  output  DW  port 0 read data
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1  same widths and meaning for port 1
- ram_addr  output  AW  to RAM address
- ram_wdata  output  DW  to RAM data
- ram_wren  output  1  to RAM write enable
- ram_q  input  DW  RAM read data, valid one cycle after the read address is sampled

Behaviour:
- State registers:
  - last (1 bit, last granted port)
  - locked (1 bit), owner (1 bit)
  - rd_pend (1 bit), rd_port (1 bit)
- Reset (reset=0 at a rising edge):
  - last=1, so port 0 wins the first tie.
  - locked=0, owner=0, rd_pend=0.
- While reset=0:
  - gnt0=gnt1=0, ram_wren=0, rvalid0=rvalid1=0.
  - rdata0/rdata1 are don't-care.
  - A read pending when reset falls is discarded; no rvalid is produced.
- Grant logic (combinational, reset=1):
  - locked=1: only the owner may be granted. gnt[owner]=req[owner]; the other gnt=0.
  - locked=0, one request: grant it.
  - locked=0, both requesting: grant port !last.
  - No request: no grant.
  - At most one gnt is high in any cycle.
- RAM drive:
  - ram_addr/ram_wdata come from the granted port.
  - ram_wren = granted port's we, and is 0 when nothing is granted.
  - With no grant, ram_addr/ram_wdata hold port 0 values (value irrelevant because wren=0).
- Acceptance: a transaction is accepted on a rising edge where reqX & gntX. Requesters hold addr/we/wdata stable while req=1 and gnt=0.
- On acceptance:
  - last <= X.
  - Read: rd_pend <= 1, rd_port <= X. Otherwise rd_pend <= 0.
- Read return:
  - One cycle after an accepted read, rvalid[rd_port]=1 and rdata[rd_port]=ram_q; the other port's rvalid stays 0.
  - Latency from accepted read to rvalid is exactly 1 cycle.
  - Back-to-back reads (including alternating ports) give one rvalid per cycle, in order.
- Lock:
  - Accepted with lockX=1: locked <= 1, owner <= X.
  - Accepted with lockX=0 while the owner is X: locked <= 0 at that edge.
  - Owner drops reqX while locked: locked <= 0 at that edge, and the other port may be granted in the next cycle.
- Write-then-read of the same address on consecutive cycles returns the new data.
- Simultaneous req0/req1 on the cycle a lock is released: the released owner's last value applies, so the other port wins.

Test Plan:
- Reset, then only req0 writes 0x55 to addresses 0x00..0xFF back-to-back. Expect gnt0=1 every cycle, ram_wren=1, 256 writes, gnt1=0 throughout.
- req0 and req1 both held with reads to 0x10 and 0x20. Expect grants alternating 0,1,0,1 starting with port 0, and rvalid0/rvalid1 alternating one cycle later with the correct data.
- Port 0 read 0x05 with lock0=1, then write 0xAA to 0x05 with lock0=0, while req1 is held. Expect gnt1=0 for both cycles, gnt1=1 in the third cycle, and rdata0 = the prior contents.
- Port 1 locks and then drops req1 while req0 is asserted. Expect gnt0=1 in the cycle after the drop.
- Port 1 writes 0x3C to 0x7F, then port 1 reads 0x7F. Expect rvalid1=1 with rdata1=0x3C exactly 1 cycle after the read grant.
- Assert reset=0 in the cycle after an accepted read. Expect no rvalid, gnt=0, and ram_wren=0. After release, the first tie goes to port 0.
